// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking-lot blocks (sensor, gate controller, top level).
package parking_pkg;

    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        OPEN   = 2'd1,
        CLEAR  = 2'd2
    } gate_state_t;

    localparam int LOT_CAPACITY    = 25;
    localparam int LOT_TIMEOUT_CYC = 16;

endpackage

// File: rtl/lot_counter.sv
// Saturating up/down car counter with full/empty compares and a sticky
// overflow/underflow error flag.
module lot_counter #(
    parameter int CAPACITY = parking_pkg::LOT_CAPACITY,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter,
    input  logic             exit,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             err
);

    assign full  = (occupancy == CNT_W'(CAPACITY));
    assign empty = (occupancy == '0);

    // Simultaneous enter and exit nets to zero; an illegal move holds the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
            err       <= 1'b0;
        end else begin
            case ({enter, exit})
                2'b10: begin
                    if (full) err <= 1'b1;
                    else      occupancy <= occupancy + CNT_W'(1);
                end
                2'b01: begin
                    if (empty) err <= 1'b1;
                    else       occupancy <= occupancy - CNT_W'(1);
                end
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/lot_gate_ctrl.sv
// Lot occupancy tracker and entry-gate sequencer (CLOSED -> OPEN -> CLEAR).
// Define LOT_TIMEOUT_EN to close an unused open gate after TIMEOUT_CYC cycles.
module lot_gate_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY    = LOT_CAPACITY,
    parameter int CNT_W       = $clog2(CAPACITY + 1)
`ifdef LOT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = LOT_TIMEOUT_CYC
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter,
    input  logic             exit,
    input  logic             req,
    output logic             gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             rejected,
    output logic             timeout,
    output logic             err,
    output gate_state_t      state
);

    logic req_q;
    logic req_rise;

    assign req_rise = req & ~req_q;

    lot_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .enter     (enter),
        .exit      (exit),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

`ifdef LOT_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] timer;
`else
    assign timeout = 1'b0;
`endif

    // Outputs are registered alongside the state so gate_open tracks the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLOSED;
            gate_open <= 1'b0;
            rejected  <= 1'b0;
            req_q     <= 1'b0;
`ifdef LOT_TIMEOUT_EN
            timeout   <= 1'b0;
            timer     <= '0;
`endif
        end else begin
            req_q    <= req;
            rejected <= 1'b0;
`ifdef LOT_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
            case (state)
                CLOSED: begin
                    if (req_rise) begin
                        if (full) begin
                            rejected <= 1'b1;
                        end else begin
                            state     <= OPEN;
                            gate_open <= 1'b1;
`ifdef LOT_TIMEOUT_EN
                            timer     <= '0;
`endif
                        end
                    end
                end
                OPEN: begin
                    // An entry in the expiry cycle counts as a normal admission.
                    if (enter) begin
                        state     <= CLEAR;
                        gate_open <= 1'b0;
                    end
`ifdef LOT_TIMEOUT_EN
                    else if (timer == TIMER_LAST) begin
                        state     <= CLEAR;
                        gate_open <= 1'b0;
                        timeout   <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
`endif
                end
                CLEAR: begin
                    // Hold closed until the request drops so a following car cannot tailgate.
                    if (!req) state <= CLOSED;
                end
                default: begin
                    state     <= CLOSED;
                    gate_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lot_gate_ctrl.sv
// Self-checking bench for lot_gate_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against an occupancy/gate reference model.
module tb_lot_gate_ctrl;
    import parking_pkg::*;

    localparam int CAP   = 3;
    localparam int TO    = 4;
    localparam int W     = $clog2(CAP + 1);

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enter = 1'b0;
    logic         exit = 1'b0;
    logic         req = 1'b0;
    logic         gate_open;
    logic [W-1:0] occupancy;
    logic         full, empty, rejected, timeout, err;
    gate_state_t  state;

    int n_checks = 0;
    int n_fail   = 0;

    lot_gate_ctrl #(
        .CAPACITY    (CAP),
        .CNT_W       (W)
`ifdef LOT_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (TO)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enter     (enter),
        .exit      (exit),
        .req       (req),
        .gate_open (gate_open),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty),
        .rejected  (rejected),
        .timeout   (timeout),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic e, input logic x, input logic r);
        enter = e;
        exit  = x;
        req   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enter = 1'b0;
        exit  = 1'b0;
        req   = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    int   m_cars;
    bit   m_err, m_gate, m_waiting_release, m_req_prev, m_rej, m_to;
    int   m_open_cycles;
    bit   timeout_en;

    task automatic model_reset();
        m_cars = 0; m_err = 0; m_gate = 0; m_waiting_release = 0;
        m_req_prev = 0; m_rej = 0; m_to = 0; m_open_cycles = 0;
    endtask

    task automatic model_step(input bit e, input bit x, input bit r);
        bit was_full, was_empty, rising;
        was_full  = (m_cars == CAP);
        was_empty = (m_cars == 0);
        rising    = r && !m_req_prev;
        m_rej = 0;
        m_to  = 0;
        if (m_gate) begin
            if (e) begin
                m_gate = 0; m_waiting_release = 1;
            end else if (timeout_en && m_open_cycles == TO - 1) begin
                m_gate = 0; m_waiting_release = 1; m_to = 1;
            end else begin
                m_open_cycles++;
            end
        end else if (m_waiting_release) begin
            if (!r) m_waiting_release = 0;
        end else if (rising) begin
            if (was_full) m_rej = 1;
            else begin m_gate = 1; m_open_cycles = 0; end
        end
        if (e && !x) begin
            if (was_full) m_err = 1; else m_cars++;
        end else if (x && !e) begin
            if (was_empty) m_err = 1; else m_cars--;
        end
        m_req_prev = r;
    endtask

    task automatic compare_model();
        check("rnd_occupancy", 32'(occupancy), 32'(m_cars));
        check("rnd_full", 32'(full), 32'(m_cars == CAP));
        check("rnd_empty", 32'(empty), 32'(m_cars == 0));
        check("rnd_gate_open", 32'(gate_open), 32'(m_gate));
        check("rnd_rejected", 32'(rejected), 32'(m_rej));
        check("rnd_timeout", 32'(timeout), 32'(m_to));
        check("rnd_err", 32'(err), 32'(m_err));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        e, x, r;
        int          occ;
        logic        gate, fl, em, rej, er;
        gate_state_t st;
    } vec_t;

    function automatic vec_t mk(logic e, logic x, logic r, int occ, logic gate,
                                logic fl, logic em, logic rej, logic er, gate_state_t st);
        vec_t v;
        v.e = e; v.x = x; v.r = r; v.occ = occ; v.gate = gate;
        v.fl = fl; v.em = em; v.rej = rej; v.er = er; v.st = st;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        timeout_en = 1'b0;
`ifdef LOT_TIMEOUT_EN
        timeout_en = 1'b1;
`endif
        //            e  x  r  occ g  f  em rj er state
        tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, CLOSED);
        tbl[1]  = mk(1, 0, 0, 2, 0, 0, 0, 0, 0, CLOSED);
        tbl[2]  = mk(1, 0, 0, 3, 0, 1, 0, 0, 0, CLOSED);
        tbl[3]  = mk(1, 0, 0, 3, 0, 1, 0, 0, 1, CLOSED);
        tbl[4]  = mk(0, 0, 1, 3, 0, 1, 0, 1, 1, CLOSED);
        tbl[5]  = mk(0, 0, 1, 3, 0, 1, 0, 0, 1, CLOSED);
        tbl[6]  = mk(0, 1, 0, 2, 0, 0, 0, 0, 1, CLOSED);
        tbl[7]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 1, CLOSED);
        tbl[8]  = mk(0, 0, 1, 1, 1, 0, 0, 0, 1, OPEN);
        tbl[9]  = mk(1, 0, 1, 2, 0, 0, 0, 0, 1, CLEAR);
        tbl[10] = mk(0, 0, 1, 2, 0, 0, 0, 0, 1, CLEAR);
        tbl[11] = mk(0, 0, 0, 2, 0, 0, 0, 0, 1, CLOSED);
        tbl[12] = mk(0, 0, 1, 2, 1, 0, 0, 0, 1, OPEN);
        tbl[13] = mk(1, 1, 1, 2, 0, 0, 0, 0, 1, CLEAR);
        tbl[14] = mk(0, 0, 0, 2, 0, 0, 0, 0, 1, CLOSED);
        tbl[15] = mk(0, 1, 0, 1, 0, 0, 0, 0, 1, CLOSED);
        tbl[16] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1, CLOSED);
        tbl[17] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1, CLOSED);

        // Reset values
        do_reset();
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_gate_open", 32'(gate_open), 0);
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_rejected", 32'(rejected), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_err", 32'(err), 0);
        check("rst_state", 32'(state), 32'(CLOSED));

        foreach (tbl[i]) begin
            step(tbl[i].e, tbl[i].x, tbl[i].r);
            check($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].occ));
            check($sformatf("vec%0d_gate_open", i), 32'(gate_open), 32'(tbl[i].gate));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].fl));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].em));
            check($sformatf("vec%0d_rejected", i), 32'(rejected), 32'(tbl[i].rej));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].er));
            check($sformatf("vec%0d_timeout", i), 32'(timeout), 0);
            check($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
        end

        // Underflow from a fresh reset sets err
        do_reset();
        step(0, 1, 0);
        check("underflow_err", 32'(err), 1);
        check("underflow_occupancy", 32'(occupancy), 0);

        // Asynchronous reset while the gate is open
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        check("pre_rst_gate_open", 32'(gate_open), 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_gate_open", 32'(gate_open), 0);
        check("async_rst_occupancy", 32'(occupancy), 0);
        check("async_rst_empty", 32'(empty), 1);
        check("async_rst_state", 32'(state), 32'(CLOSED));
        req = 1'b0;
        #2 reset = 1'b0;

        // Unused open gate: times out with the macro, stays open without it
        do_reset();
        step(0, 0, 1);
        check("dwell_gate_first", 32'(gate_open), 1);
`ifdef LOT_TIMEOUT_EN
        for (int i = 0; i < TO - 1; i++) begin
            step(0, 0, 1);
            check("dwell_gate_open", 32'(gate_open), 1);
            check("dwell_timeout_low", 32'(timeout), 0);
        end
        step(0, 0, 1);
        check("expiry_gate_open", 32'(gate_open), 0);
        check("expiry_timeout_pulse", 32'(timeout), 1);
        step(0, 0, 1);
        check("expiry_timeout_one_cycle", 32'(timeout), 0);
        check("expiry_state_clear", 32'(state), 32'(CLEAR));

        // Entry in the expiry cycle wins over the timeout
        do_reset();
        for (int i = 0; i < TO; i++) step(0, 0, 1);
        step(1, 0, 1);
        check("enter_wins_timeout", 32'(timeout), 0);
        check("enter_wins_gate", 32'(gate_open), 0);
        check("enter_wins_occupancy", 32'(occupancy), 1);
`else
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 1);
            check("hold_gate_open", 32'(gate_open), 1);
            check("hold_timeout_low", 32'(timeout), 0);
        end
`endif

        // Randomized run against the reference model
        do_reset();
        model_reset();
        begin
            bit e, x, r;
            r = 1'b0;
            for (int i = 0; i < 600; i++) begin
                e = ($urandom_range(0, 2) == 0);
                x = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 3) == 0) r = ~r;
                step(e, x, r);
                model_step(e, x, r);
                compare_model();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
